mdisplay_scan: RTL and testbench

Multi-digit, time-multiplexed 7-segment display controller. Holds a shadow copy of NUM_DIGITS BCD digits plus decimal points and scans one digit at a time onto a shared segment bus with per-digit anode enables. A blanking gap between digits prevents ghosting, and leading zeros can optionally be suppressed. Sits between the spirometer measurement/BCD datapath and the board's common-anode display.

---
 rtl/mdisplay_pkg.sv | 25 ++
 rtl/seg7_decode.sv | 30 +++
 rtl/mdisplay_scan.sv | 126 ++++++++++++
 tb/tb_mdisplay_scan.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mdisplay_pkg.sv
// Shared constants for the multiplexed 7-segment display path: segment
// patterns (active-low {a..g}), scan state encoding and anode polarity helper.
package mdisplay_pkg;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0001100;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [0:0] ST_GAP  = 1'b0;
   localparam logic [0:0] ST_SHOW = 1'b1;

   // Physical level for an anode given whether it is logically selected.
   function automatic logic anode_level(input logic active, input logic active_low);
      return active_low ? ~active : active;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder with a blank override.
// Nibbles 10..15 decode to blank.
module seg7_decode
   import mdisplay_pkg::*;
(
   input  logic [3:0] i_bcd,
   input  logic       i_blank,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      if (!i_blank) begin
         case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/mdisplay_scan.sv
// Time-multiplexed multi-digit 7-segment scanner with shadow registers,
// an anti-ghosting blank gap per slot and optional leading-zero blanking.
module mdisplay_scan
   import mdisplay_pkg::*;
#(
   parameter int unsigned NUM_DIGITS       = 4,
   parameter int unsigned REFRESH_DIV      = 50000,
   parameter int unsigned GAP_CYCLES       = 500,
   parameter bit          ANODE_ACTIVE_LOW = 1'b1
) (
   input  logic                      iclk,
   input  logic                      iReset,
   input  logic                      iLoad,
   input  logic [4*NUM_DIGITS-1:0]   ivDigits,
   input  logic [NUM_DIGITS-1:0]     ivDots,
   input  logic                      iLzb,
   output logic [6:0]                ov7segmentos,
   output logic                      oDp,
   output logic [NUM_DIGITS-1:0]     ovAnodes,
   output logic                      oFrame
);

   localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] CNT_SHOW = CW'(GAP_CYCLES);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

   logic [4*NUM_DIGITS-1:0] r_digits;
   logic [NUM_DIGITS-1:0]   r_dots;
   logic [CW-1:0]           r_cnt;
   logic [IW-1:0]           r_idx;
   logic [0:0]              r_state;
   logic [6:0]              r_seg;
   logic                    r_dp;
   logic [NUM_DIGITS-1:0]   r_anodes;
   logic                    r_frame;

   logic [3:0]              w_nib;
   logic                    w_dot;
   logic                    w_upper_nz;
   logic                    w_blank;
   logic [6:0]              w_seg;
   logic [NUM_DIGITS-1:0]   w_anodes_sel;
   logic [NUM_DIGITS-1:0]   w_anodes_off;
   logic [0:0]              w_state_d;

   // Select the current digit and check whether it or any more significant digit is non-zero.
   always_comb begin
      w_nib        = 4'd0;
      w_dot        = 1'b0;
      w_upper_nz   = 1'b0;
      w_anodes_sel = '0;
      w_anodes_off = '0;
      for (int j = 0; j < NUM_DIGITS; j++) begin
         if (IW'(j) == r_idx) begin
            w_nib = r_digits[4*j +: 4];
            w_dot = r_dots[j];
         end
         if ((IW'(j) >= r_idx) && (r_digits[4*j +: 4] != 4'd0)) begin
            w_upper_nz = 1'b1;
         end
         w_anodes_sel[j] = anode_level(IW'(j) == r_idx, ANODE_ACTIVE_LOW);
         w_anodes_off[j] = anode_level(1'b0, ANODE_ACTIVE_LOW);
      end
      w_blank = iLzb && (r_idx != '0) && !w_upper_nz;
   end

   seg7_decode u_decode (
      .i_bcd   (w_nib),
      .i_blank (w_blank),
      .o_seg   (w_seg)
   );

   // Outputs describe the slot position r_cnt held before the edge.
   always_comb begin
      w_state_d = r_state;
      case (r_state)
         ST_GAP:  if (r_cnt == CNT_SHOW) w_state_d = ST_SHOW;
         ST_SHOW: if (r_cnt == '0)       w_state_d = ST_GAP;
         default: w_state_d = ST_GAP;
      endcase
   end

   always_ff @(posedge iclk) begin
      if (iReset) begin
         r_digits <= '0;
         r_dots   <= '0;
         r_cnt    <= '0;
         r_idx    <= '0;
         r_state  <= ST_GAP;
         r_seg    <= SEG_BLANK;
         r_dp     <= 1'b1;
         r_anodes <= w_anodes_off;
         r_frame  <= 1'b0;
      end else begin
         if (iLoad) begin
            r_digits <= ivDigits;
            r_dots   <= ivDots;
         end
         if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
         r_state <= w_state_d;
         r_frame <= (r_cnt == '0) && (r_idx == '0);
         if ((r_state == ST_GAP) && (w_state_d == ST_SHOW)) begin
            r_seg    <= w_seg;
            r_dp     <= ~w_dot;
            r_anodes <= w_anodes_sel;
         end else if (w_state_d == ST_GAP) begin
            r_seg    <= SEG_BLANK;
            r_dp     <= 1'b1;
            r_anodes <= w_anodes_off;
         end
      end
   end

   assign ov7segmentos = r_seg;
   assign oDp          = r_dp;
   assign ovAnodes     = r_anodes;
   assign oFrame       = r_frame;

endmodule

// File: tb/tb_mdisplay_scan.sv
// Self-checking bench for mdisplay_scan: directed scenarios plus random loads,
// compared each cycle against a slot-arithmetic reference model.
module tb_mdisplay_scan;

   localparam int N = 4;
   localparam int R = 8;
   localparam int G = 2;

   logic        iclk = 1'b0;
   logic        iReset = 1'b1;
   logic        iLoad = 1'b0;
   logic [15:0] ivDigits = '0;
   logic [3:0]  ivDots = '0;
   logic        iLzb = 1'b0;
   logic [6:0]  ov7segmentos;
   logic        oDp;
   logic [3:0]  ovAnodes;
   logic        oFrame;

   mdisplay_scan #(
      .NUM_DIGITS       (N),
      .REFRESH_DIV      (R),
      .GAP_CYCLES       (G),
      .ANODE_ACTIVE_LOW (1'b1)
   ) dut (
      .iclk         (iclk),
      .iReset       (iReset),
      .iLoad        (iLoad),
      .ivDigits     (ivDigits),
      .ivDots       (ivDots),
      .iLzb         (iLzb),
      .ov7segmentos (ov7segmentos),
      .oDp          (oDp),
      .ovAnodes     (ovAnodes),
      .oFrame       (oFrame)
   );

   always #5 iclk = ~iclk;

   int n_checks = 0;
   int n_errors = 0;

   logic [6:0]  seg_tab [16];
   int          m_n = 0;
   logic [15:0] m_dig = '0;
   logic [3:0]  m_dot = '0;
   logic [6:0]  m_seg = 7'h7f;
   logic        m_dp = 1'b1;
   logic [3:0]  m_an = 4'hf;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s t=%0t got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   // One clock: drive inputs, predict outputs after the edge, compare at edge+1.
   task automatic step(input logic ld, input logic [15:0] dg, input logic [3:0] dt,
                       input logic lz, input logic rs);
      logic [6:0] e_seg;
      logic       e_dp;
      logic [3:0] e_an;
      logic       e_fr;
      int         pos;
      int         dig;
      logic [3:0] nib;
      iLoad    = ld;
      ivDigits = dg;
      ivDots   = dt;
      iLzb     = lz;
      iReset   = rs;
      e_seg = 7'h7f;
      e_dp  = 1'b1;
      e_an  = 4'hf;
      e_fr  = 1'b0;
      if (!rs) begin
         pos  = m_n % R;
         dig  = (m_n / R) % N;
         e_fr = (pos == 0) && (dig == 0);
         if (pos == G) begin
            nib = m_dig[4*dig +: 4];
            if (lz && (dig != 0) && ((m_dig >> (4 * dig)) == 16'h0)) m_seg = 7'h7f;
            else m_seg = seg_tab[nib];
            m_dp = ~m_dot[dig];
            m_an = ~(4'b0001 << dig);
         end
         if (pos >= G) begin
            e_seg = m_seg;
            e_dp  = m_dp;
            e_an  = m_an;
         end
         m_n++;
      end else begin
         m_n = 0;
      end
      if (rs) begin
         m_dig = '0;
         m_dot = '0;
      end else if (ld) begin
         m_dig = dg;
         m_dot = dt;
      end
      @(posedge iclk);
      #1;
      check_eq("segments", 32'(ov7segmentos), 32'(e_seg));
      check_eq("dp", 32'(oDp), 32'(e_dp));
      check_eq("anodes", 32'(ovAnodes), 32'(e_an));
      check_eq("frame", 32'(oFrame), 32'(e_fr));
      check_eq("anode_onehot", 32'($countones(~ovAnodes) <= 1), 32'd1);
   endtask

   task automatic idle(input int k, input logic lz);
      for (int i = 0; i < k; i++) step(1'b0, 16'h0, 4'h0, lz, 1'b0);
   endtask

   // Advance until the next predicted output cycle is (digit, position).
   task automatic run_to(input int dig_t, input int pos_t, input logic lz);
      for (int i = 0; i < 64; i++) begin
         if (((m_n % R) == pos_t) && (((m_n / R) % N) == dig_t)) break;
         step(1'b0, 16'h0, 4'h0, lz, 1'b0);
      end
   endtask

   initial begin
      logic [15:0] rd;
      seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111;
      seg_tab[2] = 7'b0010010; seg_tab[3] = 7'b0000110;
      seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
      seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111;
      seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0001100;
      for (int i = 10; i < 16; i++) seg_tab[i] = 7'b1111111;

      for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
      idle(10, 1'b0);

      step(1'b1, 16'h1234, 4'b0100, 1'b0, 1'b0);
      idle(70, 1'b0);

      step(1'b1, 16'h0057, 4'b0000, 1'b1, 1'b0);
      idle(34, 1'b1);
      step(1'b1, 16'h0000, 4'b0000, 1'b1, 1'b0);
      idle(34, 1'b1);

      step(1'b1, 16'h1234, 4'b0000, 1'b0, 1'b0);
      run_to(1, 4, 1'b0);
      step(1'b1, 16'h9999, 4'b0000, 1'b0, 1'b0);
      idle(34, 1'b0);

      step(1'b1, 16'h123A, 4'b0001, 1'b0, 1'b0);
      idle(34, 1'b0);

      for (int i = 0; i < 1000; i++) begin
         for (int k = 0; k < 4; k++) begin
            rd[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         end
         step(($urandom_range(0, 7) == 0), rd, 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 299) == 0));
      end

      step(1'b1, 16'h5678, 4'b1111, 1'b0, 1'b0);
      run_to(2, 4, 1'b0);
      step(1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
      idle(40, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
